// File: rtl/coin_acceptor.sv
// coin_acceptor
//   Front end for the vending controller. Synchronises and debounces the raw
//   coin-sensor level, measures how long the coin blocks the beam and turns
//   that width into a one-cycle denomination pulse (5 or 10), a one-cycle
//   reject pulse, or a jam level when the beam stays blocked too long.
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   sense      raw asynchronous sensor level, high while a coin blocks the beam
//   accept_en  gate open; sampled only on the classify edge
//   coin[4:0]  5 or 10 for exactly one cycle, otherwise 0
//   reject     one-cycle pulse: invalid width or gate closed
//   jam        level, sensor blocked for TIMEOUT cycles
//   n_accept / n_reject [15:0]  saturating pulse counters, present only when
//                               COIN_ACCEPTOR_STATS_EN is defined
//
// State table
//   IDLE    | waiting for the debounced level to go high
//   MEASURE | coin in the beam, width counter running
//   JAM     | beam blocked for TIMEOUT cycles, waiting for release
module coin_acceptor #(
  parameter int DEB_CYCLES = 4,
  parameter int MIN5       = 10,
  parameter int MAX5       = 19,
  parameter int MIN10      = 20,
  parameter int MAX10      = 39,
  parameter int TIMEOUT    = 63
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sense,
  input  logic       accept_en,
  output logic [4:0] coin,
  output logic       reject,
  output logic       jam
`ifdef COIN_ACCEPTOR_STATS_EN
  ,
  output logic [15:0] n_accept,
  output logic [15:0] n_reject
`endif
);

  localparam int DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [7:0] MIN5_W    = 8'(MIN5);
  localparam logic [7:0] MAX5_W    = 8'(MAX5);
  localparam logic [7:0] MIN10_W   = 8'(MIN10);
  localparam logic [7:0] MAX10_W   = 8'(MAX10);
  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    JAM     = 2'd2
  } state_t;

  state_t          state;
  logic            s1, s2;
  logic            db;
  logic [DW-1:0]   deb_cnt;
  logic [7:0]      w;
  logic [7:0]      w_inc;
  logic            in5, in10;

  assign w_inc = w + 8'd1;
  assign in5   = (w >= MIN5_W)  && (w <= MAX5_W);
  assign in10  = (w >= MIN10_W) && (w <= MAX10_W);

  // Synchroniser and debouncer. The counter only runs while the synchronised
  // level disagrees with db; any agreement clears it, so a glitch shorter
  // than DEB_CYCLES never reaches db.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      db      <= 1'b0;
      deb_cnt <= '0;
    end else begin
      s1 <= sense;
      s2 <= s1;
      if (s2 != db) begin
        if (deb_cnt == DEB_LAST) begin
          db      <= s2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // Width measurement and classification. coin/reject default low every
  // cycle so each is a single-cycle pulse on the classify edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      w      <= 8'd0;
      coin   <= 5'd0;
      reject <= 1'b0;
      jam    <= 1'b0;
    end else begin
      coin   <= 5'd0;
      reject <= 1'b0;
      case (state)
        IDLE: begin
          if (db) begin
            state <= MEASURE;
            w     <= 8'd1;
          end
        end
        MEASURE: begin
          if (db) begin
            w <= w_inc;
            // Entering JAM here keeps w well below its 8-bit limit.
            if (w_inc == TIMEOUT_W) begin
              state <= JAM;
              jam   <= 1'b1;
            end
          end else begin
            state <= IDLE;
            if (!accept_en)
              reject <= 1'b1;
            else if (in5)
              coin <= 5'd5;
            else if (in10)
              coin <= 5'd10;
            else
              reject <= 1'b1;
          end
        end
        JAM: begin
          if (!db) begin
            state <= IDLE;
            jam   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          jam   <= 1'b0;
        end
      endcase
    end
  end

`ifdef COIN_ACCEPTOR_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      n_accept <= 16'd0;
      n_reject <= 16'd0;
    end else begin
      if ((coin != 5'd0) && (n_accept != 16'hFFFF))
        n_accept <= n_accept + 16'd1;
      if (reject && (n_reject != 16'hFFFF))
        n_reject <= n_reject + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed testbench for coin_acceptor. A sensor pattern is played one bit
// per cycle; bit t is the level seen by clock edge t+1, and outputs sampled
// on the falling edge after edge t are tagged with index t. A clean N-cycle
// pulse starting at bit 0 therefore yields its pulse at index N+7.
module tb_coin_acceptor;

  logic       clk = 1'b0;
  logic       rst;
  logic       sense;
  logic       accept_en;
  logic [4:0] coin;
  logic       reject;
  logic       jam;
`ifdef COIN_ACCEPTOR_STATS_EN
  logic [15:0] n_accept;
  logic [15:0] n_reject;
`endif

  int checks = 0;
  int errors = 0;

  // event log of the last played pattern; value 100 marks a reject
  int ev_n;
  int ev_cyc [8];
  int ev_val [8];
  int both_n;
  int jam_first;
  int jam_last;

  always #5 clk = ~clk;

  coin_acceptor dut (
    .clk       (clk),
    .rst       (rst),
    .sense     (sense),
    .accept_en (accept_en),
    .coin      (coin),
    .reject    (reject),
    .jam       (jam)
`ifdef COIN_ACCEPTOR_STATS_EN
    ,
    .n_accept  (n_accept),
    .n_reject  (n_reject)
`endif
  );

  task automatic play(input logic [127:0] pat, input int len);
    ev_n      = 0;
    both_n    = 0;
    jam_first = -1;
    jam_last  = -1;
    for (int i = 0; i < 8; i++) begin
      ev_cyc[i] = -1;
      ev_val[i] = 0;
    end
    for (int t = 0; t < len; t++) begin
      @(negedge clk);
      if (coin != 5'd0 || reject) begin
        if (ev_n < 8) begin
          ev_cyc[ev_n] = t;
          ev_val[ev_n] = (coin != 5'd0) ? int'(coin) : 100;
        end
        ev_n++;
      end
      if (coin != 5'd0 && reject) both_n++;
      if (jam) begin
        if (jam_first < 0) jam_first = t;
        jam_last = t;
      end
      sense = pat[t];
    end
    sense = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (coin !== 5'd0) begin errors++; $display("FAIL reset_coin got %0d want 0", coin); end
    checks++;
    if (reject !== 1'b0) begin errors++; $display("FAIL reset_reject got %0b want 0", reject); end
    checks++;
    if (jam !== 1'b0) begin errors++; $display("FAIL reset_jam got %0b want 0", jam); end
`ifdef COIN_ACCEPTOR_STATS_EN
    checks++;
    if (n_accept !== 16'd0 || n_reject !== 16'd0) begin
      errors++; $display("FAIL reset_stats got %0d/%0d want 0/0", n_accept, n_reject);
    end
`endif
  endtask

  // one clean pulse of the given width; exactly one event expected
  task automatic test_single(input string name, input int width, input int exp_val);
    logic [127:0] pat;
    pat = '0;
    for (int i = 0; i < width; i++) pat[i] = 1'b1;
    play(pat, width + 15);
    checks++;
    if (ev_n !== 1) begin errors++; $display("FAIL %s_count got %0d want 1", name, ev_n); end
    checks++;
    if (ev_val[0] !== exp_val) begin errors++; $display("FAIL %s_value got %0d want %0d", name, ev_val[0], exp_val); end
    checks++;
    if (ev_cyc[0] !== width + 7) begin errors++; $display("FAIL %s_latency got %0d want %0d", name, ev_cyc[0], width + 7); end
    checks++;
    if (both_n !== 0) begin errors++; $display("FAIL %s_exclusive got %0d want 0", name, both_n); end
  endtask

  task automatic test_boundaries();
    int widths [6] = '{9, 10, 19, 20, 39, 40};
    int exps   [6] = '{100, 5, 5, 10, 10, 100};
    for (int k = 0; k < 6; k++)
      test_single($sformatf("edge_w%0d", widths[k]), widths[k], exps[k]);
  endtask

  task automatic test_glitch();
    logic [127:0] pat;
    pat = '0;
    for (int i = 0; i < 3; i++) pat[i] = 1'b1;
    play(pat, 30);
    checks++;
    if (ev_n !== 0) begin errors++; $display("FAIL glitch_count got %0d want 0", ev_n); end
    // 6 high, 2-cycle notch, 7 high: spans 15 cycles
    pat = '0;
    for (int i = 0; i < 15; i++) pat[i] = 1'b1;
    pat[6] = 1'b0;
    pat[7] = 1'b0;
    play(pat, 30);
    checks++;
    if (ev_n !== 1) begin errors++; $display("FAIL notch_count got %0d want 1", ev_n); end
    checks++;
    if (ev_val[0] !== 5 || ev_cyc[0] !== 22) begin
      errors++; $display("FAIL notch_coin got %0d at %0d want 5 at 22", ev_val[0], ev_cyc[0]);
    end
  endtask

  task automatic test_jam();
    logic [127:0] pat;
    pat = '0;
    for (int i = 0; i < 100; i++) pat[i] = 1'b1;
    play(pat, 120);
    checks++;
    if (ev_n !== 0) begin errors++; $display("FAIL jam_pulses got %0d want 0", ev_n); end
    checks++;
    if (jam_first !== 69) begin errors++; $display("FAIL jam_rise got %0d want 69", jam_first); end
    checks++;
    if (jam_last !== 106) begin errors++; $display("FAIL jam_fall got %0d want 106", jam_last); end
    test_single("after_jam", 15, 5);
  endtask

  task automatic test_gate_closed();
    accept_en = 1'b0;
    test_single("gate_closed", 15, 100);
    accept_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [127:0] pat;
    pat = '0;
    for (int i = 0; i < 15; i++) pat[i] = 1'b1;
    for (int i = 21; i < 46; i++) pat[i] = 1'b1;
    play(pat, 65);
    checks++;
    if (ev_n !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", ev_n); end
    checks++;
    if (ev_val[0] !== 5 || ev_cyc[0] !== 22) begin
      errors++; $display("FAIL b2b_first got %0d at %0d want 5 at 22", ev_val[0], ev_cyc[0]);
    end
    checks++;
    if (ev_val[1] !== 10 || ev_cyc[1] !== 53) begin
      errors++; $display("FAIL b2b_second got %0d at %0d want 10 at 53", ev_val[1], ev_cyc[1]);
    end
  endtask

  task automatic test_stats(input int exp_acc, input int exp_rej);
`ifdef COIN_ACCEPTOR_STATS_EN
    checks++;
    if (n_accept !== 16'(exp_acc)) begin errors++; $display("FAIL stats_accept got %0d want %0d", n_accept, exp_acc); end
    checks++;
    if (n_reject !== 16'(exp_rej)) begin errors++; $display("FAIL stats_reject got %0d want %0d", n_reject, exp_rej); end
`endif
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    sense = 1'b1;
    repeat (14) @(negedge clk);
    rst   = 1'b1;
    sense = 1'b0;
    @(negedge clk);
    checks++;
    if (coin !== 5'd0 || reject !== 1'b0 || jam !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got %0d/%0b/%0b want 0/0/0", coin, reject, jam);
    end
    rst = 1'b0;
    play('0, 30);
    checks++;
    if (ev_n !== 0 || jam_first !== -1) begin
      errors++; $display("FAIL midrst_quiet got %0d events jam %0d want 0 events jam -1", ev_n, jam_first);
    end
  endtask

  initial begin
    rst       = 1'b1;
    sense     = 1'b0;
    accept_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_single("coin5", 15, 5);
    test_single("coin10", 25, 10);
    test_single("short", 5, 100);
    test_single("long", 45, 100);
    test_boundaries();
    test_glitch();
    test_jam();
    test_gate_closed();
    test_back_to_back();
    // coins: 15,25, 10,19,20,39, notch, after-jam, b2b x2 ; rejects: 5,45,9,40,gate
    test_stats(10, 5);
    test_reset_mid();
    test_stats(0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
